wb_bram_arbiter: RTL and testbench

- Two-master Wishbone arbiter that shares one Wishbone slave port, normally the block RAM controller, between two requesters (e.g. video reader and CPU/bus bridge).
- Grants whole bus cycles (`cyc` ownership), so classic and burst (`cti`-tagged) transfers are never interleaved.
- Simultaneous requests are resolved round-robin.
- Sits between the master-side Wishbone interfaces and the single `wshb_if` slave instance of the memory.

---
 rtl/wb_bram_arbiter_if.sv | 29 ++
 rtl/wb_bram_arbiter.sv | 158 +++++++++++++++
 tb/tb_wb_bram_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bram_arbiter_if.sv
// Wishbone bus bundle shared by the arbiter, its two masters and the BRAM slave.
// master modport drives the request side; slave modport drives data/ack/err/rty back.
interface wshb_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
);
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_ms;
  logic [DW-1:0]   dat_sm;
  logic [DW/8-1:0] sel;
  logic            we;
  logic            stb;
  logic            cyc;
  logic [2:0]      cti;
  logic [1:0]      bte;
  logic            ack;
  logic            err;
  logic            rty;

  modport master (
    output adr, dat_ms, sel, we, stb, cyc, cti, bte,
    input  dat_sm, ack, err, rty
  );

  modport slave (
    input  adr, dat_ms, sel, we, stb, cyc, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_bram_arbiter.sv
// Two-master round-robin Wishbone arbiter granting whole cyc ownership of one slave.
// Optional bus-hang timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned FIRST_PRIO     = 0
) (
  input  logic       clk,
  input  logic       rst,
  wshb_if.slave      wb_m0,
  wshb_if.slave      wb_m1,
  wshb_if.master     wb_s,
  output logic [1:0] grant,
  output logic       busy
);

  if (FIRST_PRIO > 1 || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("wb_bram_arbiter: FIRST_PRIO must be 0 or 1 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t state_q, state_d;
  logic   last_owner_q, last_owner_d;
  logic   timeout_hit;
  logic   slave_resp;

  assign slave_resp = wb_s.ack | wb_s.err | wb_s.rty;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (wb_m0.cyc && wb_m1.cyc) state_d = last_owner_q ? OWN0 : OWN1;
        else if (wb_m0.cyc)         state_d = OWN0;
        else if (wb_m1.cyc)         state_d = OWN1;
      end
      OWN0: begin
        if (timeout_hit) begin
          state_d      = IDLE;
          last_owner_d = 1'b0;
        end else if (!wb_m0.cyc) begin
          last_owner_d = 1'b0;
          state_d      = wb_m1.cyc ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (timeout_hit) begin
          state_d      = IDLE;
          last_owner_d = 1'b1;
        end else if (!wb_m1.cyc) begin
          last_owner_d = 1'b1;
          state_d      = wb_m0.cyc ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= (FIRST_PRIO == 0) ? 1'b1 : 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts stalled strobe cycles of the current owner; any response or ownership change restarts it.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_d != state_q || slave_resp) tmo_cnt_d = '0;
    else if (wb_s.stb)                    tmo_cnt_d = tmo_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) tmo_cnt_q <= '0;
    else     tmo_cnt_q <= tmo_cnt_d;
  end

  assign timeout_hit = (state_q != IDLE) && (tmo_cnt_q == CW'(TIMEOUT_CYCLES));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    wb_s.adr     = '0;
    wb_s.dat_ms  = '0;
    wb_s.sel     = '0;
    wb_s.we      = 1'b0;
    wb_s.stb     = 1'b0;
    wb_s.cyc     = 1'b0;
    wb_s.cti     = '0;
    wb_s.bte     = '0;
    wb_m0.ack    = 1'b0;
    wb_m0.err    = 1'b0;
    wb_m0.rty    = 1'b0;
    wb_m1.ack    = 1'b0;
    wb_m1.err    = 1'b0;
    wb_m1.rty    = 1'b0;
    wb_m0.dat_sm = wb_s.dat_sm;
    wb_m1.dat_sm = wb_s.dat_sm;
    case (state_q)
      OWN0: begin
        wb_s.adr    = wb_m0.adr;
        wb_s.dat_ms = wb_m0.dat_ms;
        wb_s.sel    = wb_m0.sel;
        wb_s.we     = wb_m0.we;
        wb_s.stb    = wb_m0.stb;
        wb_s.cyc    = wb_m0.cyc;
        wb_s.cti    = wb_m0.cti;
        wb_s.bte    = wb_m0.bte;
        wb_m0.ack   = wb_s.ack;
        wb_m0.err   = wb_s.err;
        wb_m0.rty   = wb_s.rty;
      end
      OWN1: begin
        wb_s.adr    = wb_m1.adr;
        wb_s.dat_ms = wb_m1.dat_ms;
        wb_s.sel    = wb_m1.sel;
        wb_s.we     = wb_m1.we;
        wb_s.stb    = wb_m1.stb;
        wb_s.cyc    = wb_m1.cyc;
        wb_s.cti    = wb_m1.cti;
        wb_s.bte    = wb_m1.bte;
        wb_m1.ack   = wb_s.ack;
        wb_m1.err   = wb_s.err;
        wb_m1.rty   = wb_s.rty;
      end
      default: ;
    endcase
    // A timed-out owner gets a lone err while the slave sees the cycle end.
    if (timeout_hit) begin
      wb_s.stb  = 1'b0;
      wb_s.cyc  = 1'b0;
      wb_m0.ack = 1'b0;
      wb_m0.rty = 1'b0;
      wb_m0.err = (state_q == OWN0);
      wb_m1.ack = 1'b0;
      wb_m1.rty = 1'b0;
      wb_m1.err = (state_q == OWN1);
    end
  end

  assign grant = state_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_wb_bram_arbiter.sv
// Self-checking bench for wb_bram_arbiter: directed scenarios plus randomized two-master traffic
// checked against a word/byte-level memory model and round-robin ordering rules.
`timescale 1ns/1ps
module tb_wb_bram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wshb_if m0_if ();
  wshb_if m1_if ();
  wshb_if s_if ();
  logic [1:0] grant;
  logic       busy;

  wb_bram_arbiter #(.TIMEOUT_CYCLES(8), .FIRST_PRIO(0)) dut (
    .clk(clk), .rst(rst), .wb_m0(m0_if), .wb_m1(m1_if), .wb_s(s_if),
    .grant(grant), .busy(busy)
  );

  // BRAM slave: zero-wait combinational ack unless stuck, byte-enabled writes.
  logic [31:0] mem [0:255];
  logic        stuck = 1'b0;
  always_comb begin
    s_if.ack    = s_if.cyc && s_if.stb && !stuck;
    s_if.err    = 1'b0;
    s_if.rty    = 1'b0;
    s_if.dat_sm = mem[s_if.adr[9:2]];
  end
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (s_if.ack && s_if.we) begin
      for (int b = 0; b < 4; b++)
        if (s_if.sel[b]) mem[s_if.adr[9:2]][8*b +: 8] <= s_if.dat_ms[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:255];
  int tb_last;
  int vectors = 0;
  int miscompares = 0;
  int stray = 0;
  int m1_ack_cnt = 0;

  always @(negedge clk) begin
    if (m0_if.ack && grant !== 2'b01) stray++;
    if (m1_if.ack && grant !== 2'b10) stray++;
    if (m1_if.ack) m1_ack_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void ref_clear();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
  endfunction

  function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a[9:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic ack_of(input int m);
    return (m == 0) ? m0_if.ack : m1_if.ack;
  endfunction

  function automatic logic [31:0] dat_of(input int m);
    return (m == 0) ? m0_if.dat_sm : m1_if.dat_sm;
  endfunction

  function automatic logic [1:0] onehot(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic cyc, input logic stb, input logic we,
                       input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input logic [2:0] cti);
    if (m == 0) begin
      m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we; m0_if.adr = adr;
      m0_if.dat_ms = dat; m0_if.sel = sel; m0_if.cti = cti; m0_if.bte = 2'b00;
    end else begin
      m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we; m1_if.adr = adr;
      m1_if.dat_ms = dat; m1_if.sel = sel; m1_if.cti = cti; m1_if.bte = 2'b00;
    end
  endtask

  task automatic release_m(input int m);
    drive(m, 1'b0, 1'b0, 1'b0, '0, '0, '0, 3'b000);
  endtask

  // Classic single transfer on an otherwise idle bus; reports cycles to ack and grant at ack.
  task automatic xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat,
                      output logic [1:0] g);
    drive(m, 1'b1, 1'b1, we, adr, dat, sel, 3'b000);
    lat = 0;
    rdata = 'x;
    g = 'x;
    repeat (20) begin
      @(negedge clk);
      if (ack_of(m)) begin
        rdata = dat_of(m);
        g = grant;
        break;
      end
      step();
      lat++;
    end
    step();
    release_m(m);
    step();
    tb_last = m;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    release_m(0);
    release_m(1);
    step();
    step();
    rst = 1'b0;
    ref_clear();
    tb_last = 1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    stuck = 1'b0;
    release_m(0);
    release_m(1);
    step();
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF, 3'b000);
    step();
    step();
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant: got %b expected 00", grant); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vectors++; if (s_if.cyc !== 1'b0) begin miscompares++; $display("FAIL reset_s_cyc: got %b expected 0", s_if.cyc); end
    vectors++; if (s_if.stb !== 1'b0) begin miscompares++; $display("FAIL reset_s_stb: got %b expected 0", s_if.stb); end
    step();
    release_m(0);
    rst = 1'b0;
    ref_clear();
    tb_last = 1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] rd;
    int lat, c0;
    logic [1:0] g;
    c0 = m1_ack_cnt;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, lat, g);
    ref_write(32'h10, 32'hDEADBEEF, 4'hF);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL single_wr_latency: got %0d expected 1", lat); end
    vectors++; if (g !== 2'b01) begin miscompares++; $display("FAIL single_wr_grant: got %b expected 01", g); end
    xfer(0, 1'b0, 32'h10, '0, 4'hF, rd, lat, g);
    vectors++; if (lat !== 1) begin miscompares++; $display("FAIL single_rd_latency: got %0d expected 1", lat); end
    vectors++; if (rd !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rd_data: got %h expected deadbeef", rd); end
    vectors++; if (m1_ack_cnt - c0 !== 0) begin miscompares++; $display("FAIL single_m1_ack: got %0d acks expected 0", m1_ack_cnt - c0); end
  endtask

  task automatic sim_pair(input logic [31:0] a0, input logic [31:0] a1, input string tag);
    int w, l;
    logic [31:0] a [2];
    logic [31:0] d [2];
    w = (tb_last == 0) ? 1 : 0;
    l = 1 - w;
    a[0] = a0; a[1] = a1;
    d[0] = $urandom; d[1] = $urandom;
    drive(0, 1'b1, 1'b1, 1'b1, a[0], d[0], 4'hF, 3'b000);
    drive(1, 1'b1, 1'b1, 1'b1, a[1], d[1], 4'hF, 3'b000);
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL %s_req_cycle: grant %b expected 00", tag, grant); end
    step();
    @(negedge clk);
    vectors++; if (grant !== onehot(w)) begin miscompares++; $display("FAIL %s_first: grant %b expected %b", tag, grant, onehot(w)); end
    vectors++; if (ack_of(l) !== 1'b0) begin miscompares++; $display("FAIL %s_loser_ack: got %b expected 0", tag, ack_of(l)); end
    ref_write(a[w], d[w], 4'hF);
    step();
    release_m(w);
    @(negedge clk);
    vectors++; if (grant !== onehot(w)) begin miscompares++; $display("FAIL %s_release: grant %b expected %b", tag, grant, onehot(w)); end
    step();
    @(negedge clk);
    vectors++; if (grant !== onehot(l)) begin miscompares++; $display("FAIL %s_handover: grant %b expected %b", tag, grant, onehot(l)); end
    vectors++; if (ack_of(l) !== 1'b1) begin miscompares++; $display("FAIL %s_second_ack: got %b expected 1", tag, ack_of(l)); end
    ref_write(a[l], d[l], 4'hF);
    step();
    release_m(l);
    step();
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL %s_end: grant %b expected 00", tag, grant); end
    tb_last = l;
    step();
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    int lat;
    logic [1:0] g;
    do_reset();
    sim_pair(32'h20, 32'h24, "pair1");
    sim_pair(32'h28, 32'h2C, "pair2");
    xfer(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd, lat, g);
    ref_write(32'h30, 32'h0BADF00D, 4'hF);
    sim_pair(32'h34, 32'h38, "pair3");
    for (int i = 0; i < 7; i++) begin
      logic [31:0] ad;
      ad = 32'h20 + 32'(i) * 4;
      xfer(1, 1'b0, ad, '0, 4'hF, rd, lat, g);
      vectors++; if (rd !== ref_mem[ad[9:2]]) begin miscompares++; $display("FAIL sim_readback_%h: got %h expected %h", ad, rd, ref_mem[ad[9:2]]); end
    end
  endtask

  task automatic test_burst();
    logic [31:0] bd [4];
    logic [31:0] rd;
    int lat;
    logic [1:0] g;
    for (int b = 0; b < 4; b++) bd[b] = $urandom;
    drive(1, 1'b1, 1'b1, 1'b1, 32'h40, bd[0], 4'hF, 3'b010);
    for (int b = 0; b < 4; b++) begin
      step();
      if (b > 0) drive(1, 1'b1, 1'b1, 1'b1, 32'h40 + 32'(b) * 4, bd[b], 4'hF, (b == 3) ? 3'b111 : 3'b010);
      if (b == 1) drive(0, 1'b1, 1'b1, 1'b0, 32'h44, '0, 4'hF, 3'b000);
      @(negedge clk);
      vectors++; if (m1_if.ack !== 1'b1) begin miscompares++; $display("FAIL burst_beat%0d_ack: got %b expected 1", b, m1_if.ack); end
      vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL burst_beat%0d_grant: got %b expected 10", b, grant); end
      ref_write(32'h40 + 32'(b) * 4, bd[b], 4'hF);
    end
    step();
    release_m(1);
    @(negedge clk);
    vectors++; if (grant !== 2'b10 || m0_if.ack !== 1'b0) begin miscompares++; $display("FAIL burst_release_hold: grant %b m0_ack %b expected 10/0", grant, m0_if.ack); end
    step();
    @(negedge clk);
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL burst_m0_granted: got %b expected 01", grant); end
    vectors++; if (m0_if.ack !== 1'b1 || m0_if.dat_sm !== bd[1]) begin miscompares++; $display("FAIL burst_m0_read: ack %b data %h expected 1/%h", m0_if.ack, m0_if.dat_sm, bd[1]); end
    step();
    release_m(0);
    step();
    step();
    tb_last = 0;
    for (int b = 0; b < 4; b++) begin
      xfer(0, 1'b0, 32'h40 + 32'(b) * 4, '0, 4'hF, rd, lat, g);
      vectors++; if (rd !== bd[b]) begin miscompares++; $display("FAIL burst_mem_%0d: got %h expected %h", b, rd, bd[b]); end
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] rd;
    int lat;
    logic [1:0] g;
    xfer(0, 1'b1, 32'h80, 32'h11223344, 4'b0011, rd, lat, g);
    xfer(1, 1'b1, 32'h80, 32'hAABBCCDD, 4'b1100, rd, lat, g);
    xfer(0, 1'b0, 32'h80, '0, 4'hF, rd, lat, g);
    vectors++; if (rd !== 32'hAABB3344) begin miscompares++; $display("FAIL byte_enables: got %h expected aabb3344", rd); end
    ref_write(32'h80, 32'h11223344, 4'b0011);
    ref_write(32'h80, 32'hAABBCCDD, 4'b1100);
  endtask

  task automatic test_random();
    bit act [2];
    bit done [2];
    int dly [2];
    int t0 [2];
    logic we [2];
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [3:0] s [2];
    logic exp_stb;
    for (int m = 0; m < 2; m++) begin act[m] = 1'b0; done[m] = 1'b0; dly[m] = 0; end
    for (int t = 0; t < 400; t++) begin
      for (int m = 0; m < 2; m++) begin
        if (act[m] && done[m]) begin
          release_m(m);
          act[m] = 1'b0;
          done[m] = 1'b0;
        end else if (!act[m] && t < 370 && $urandom_range(0, 2) == 0) begin
          act[m] = 1'b1;
          t0[m] = t;
          dly[m] = $urandom_range(0, 2);
          we[m] = 1'($urandom_range(0, 1));
          a[m] = 32'h100 + 32'($urandom_range(0, 15)) * 4;
          d[m] = $urandom;
          s[m] = we[m] ? 4'($urandom_range(1, 15)) : 4'hF;
          drive(m, 1'b1, (dly[m] == 0), we[m], a[m], d[m], s[m], 3'b000);
        end else if (act[m] && dly[m] > 0) begin
          dly[m]--;
          if (dly[m] == 0) drive(m, 1'b1, 1'b1, we[m], a[m], d[m], s[m], 3'b000);
        end
      end
      @(negedge clk);
      exp_stb = (grant == 2'b01) ? m0_if.stb : (grant == 2'b10) ? m1_if.stb : 1'b0;
      vectors++; if (s_if.stb !== exp_stb) begin miscompares++; $display("FAIL rnd_fwd_stb t=%0d: got %b expected %b", t, s_if.stb, exp_stb); end
      for (int m = 0; m < 2; m++) begin
        if (act[m] && !done[m] && ack_of(m)) begin
          done[m] = 1'b1;
          vectors++; if (t - t0[m] > 12) begin miscompares++; $display("FAIL rnd_wait_m%0d: got %0d cycles expected <=12", m, t - t0[m]); end
          if (we[m]) ref_write(a[m], d[m], s[m]);
          else begin
            vectors++; if (dat_of(m) !== ref_mem[a[m][9:2]]) begin miscompares++; $display("FAIL rnd_read_m%0d @%h: got %h expected %h", m, a[m], dat_of(m), ref_mem[a[m][9:2]]); end
          end
        end
      end
      step();
    end
    vectors++; if (act[0] || act[1]) begin miscompares++; $display("FAIL rnd_drain: pending %b%b expected 00", act[1], act[0]); end
    release_m(0);
    release_m(1);
    step();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    stuck = 1'b1;
    drive(0, 1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF, 3'b000);
    for (int k = 1; k <= 9; k++) begin
      step();
      if (k == 3) drive(1, 1'b1, 1'b1, 1'b0, 32'h10, '0, 4'hF, 3'b000);
      @(negedge clk);
      vectors++; if (m0_if.err !== (k == 9)) begin miscompares++; $display("FAIL tmo_err_c%0d: got %b expected %b", k, m0_if.err, (k == 9)); end
      if (k == 9) begin
        vectors++; if (s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin miscompares++; $display("FAIL tmo_s_drop: cyc %b stb %b expected 0/0", s_if.cyc, s_if.stb); end
      end
    end
    step();
    release_m(0);
    stuck = 1'b0;
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL tmo_idle: got %b expected 00", grant); end
    step();
    @(negedge clk);
    vectors++; if (grant !== 2'b10 || m1_if.ack !== 1'b1) begin miscompares++; $display("FAIL tmo_next_owner: grant %b ack %b expected 10/1", grant, m1_if.ack); end
    step();
    release_m(1);
    step();
    step();
    tb_last = 1;
  endtask
`endif

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h60, $urandom, 4'hF, 3'b010);
    step();
    @(negedge clk);
    vectors++; if (m0_if.ack !== 1'b1) begin miscompares++; $display("FAIL rmid_beat1: got %b expected 1", m0_if.ack); end
    step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h64, $urandom, 4'hF, 3'b010);
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (m0_if.ack !== 1'b1) begin miscompares++; $display("FAIL rmid_beat2: got %b expected 1", m0_if.ack); end
    step();
    drive(0, 1'b1, 1'b1, 1'b1, 32'h68, $urandom, 4'hF, 3'b010);
    @(negedge clk);
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL rmid_grant: got %b expected 00", grant); end
    vectors++; if (s_if.cyc !== 1'b0) begin miscompares++; $display("FAIL rmid_s_cyc: got %b expected 0", s_if.cyc); end
    vectors++; if (m0_if.ack !== 1'b0) begin miscompares++; $display("FAIL rmid_no_ack: got %b expected 0", m0_if.ack); end
    step();
    rst = 1'b0;
    release_m(0);
    ref_clear();
    tb_last = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if (m0_if.ack !== 1'b0 || grant !== 2'b00) begin miscompares++; $display("FAIL rmid_after_%0d: ack %b grant %b expected 0/00", k, m0_if.ack, grant); end
      step();
    end
  endtask

  task automatic test_monitor();
    vectors++; if (stray !== 0) begin miscompares++; $display("FAIL stray_ack: got %0d expected 0", stray); end
  endtask

  initial begin
    release_m(0);
    release_m(1);
    test_reset();
    test_single();
    test_simultaneous();
    test_burst();
    test_byte_enables();
    test_random();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    test_monitor();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
